// File: rtl/mul_scheduler.sv
// mul_scheduler: two-requester round-robin front end for a single iterative
// signed shift-add multiplier. Magnitudes are multiplied unsigned over WIDTH
// RUN cycles, then the sign is applied in FIX.
//
// state | meaning
// IDLE  | sample requests, arbitrate, capture winner's operands
// RUN   | one shift-add iteration per cycle, WIDTH iterations
// FIX   | apply sign, publish result, pulse owner's done
module mul_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iReq0,
  input  logic [WIDTH-1:0]     iA0,
  input  logic [WIDTH-1:0]     iB0,
  input  logic                 iReq1,
  input  logic [WIDTH-1:0]     iA1,
  input  logic [WIDTH-1:0]     iB1,
  output logic                 oGnt0,
  output logic                 oGnt1,
  output logic                 oDone0,
  output logic                 oDone1,
  output logic [2*WIDTH-1:0]   oResult,
  output logic [WIDTH-1:0]     oRL,
  output logic [WIDTH-1:0]     oRH,
  output logic                 oBusy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             last1;      // 1: requester 1 was granted most recently
  logic             take0, take1;
  logic [WIDTH-1:0] a_mag, mult, acc;
  logic             sign, owner;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // The most negative value maps onto itself, which read unsigned is 2^(WIDTH-1).
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // When both request, the one not granted last wins.
  assign take0 = (state == IDLE) && iReq0 && (!iReq1 || last1);
  assign take1 = (state == IDLE) && iReq1 && !take0;
  assign sel_a = take1 ? iA1 : iA0;
  assign sel_b = take1 ? iB1 : iB0;

  // Partial-product add keeps the carry so the shift below loses nothing.
  assign sum  = {1'b0, acc} + (mult[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
  assign prod = {acc, mult};

  assign oRL   = oResult[WIDTH-1:0];
  assign oRH   = oResult[2*WIDTH-1:WIDTH];
  assign oBusy = (state != IDLE);

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; RUN leaves on the edge where the counter hits zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take0 || take1) state_nxt = RUN;
      RUN:     if (cnt == CW'(1))  state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode feeding the registered pulse outputs.
  always_comb begin
    gnt0_nxt  = take0;
    gnt1_nxt  = take1;
    done0_nxt = (state == FIX) && !owner;
    done1_nxt = (state == FIX) && owner;
  end

  // Registered handshake pulses and the published product.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oGnt0   <= 1'b0;
      oGnt1   <= 1'b0;
      oDone0  <= 1'b0;
      oDone1  <= 1'b0;
      oResult <= '0;
    end else begin
      oGnt0  <= gnt0_nxt;
      oGnt1  <= gnt1_nxt;
      oDone0 <= done0_nxt;
      oDone1 <= done1_nxt;
      if (state == FIX) oResult <= sign ? -prod : prod;
    end
  end

  // Operand capture, shift-add iterations and the round-robin pointer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_mag <= '0;
      mult  <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      owner <= 1'b0;
      cnt   <= '0;
      last1 <= 1'b1;
    end else begin
      if (take0 || take1) begin
        a_mag <= mag(sel_a);
        mult  <= mag(sel_b);
        acc   <= '0;
        sign  <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
        owner <= take1;
        cnt   <= CW'(WIDTH);
        last1 <= take1;
      end else if (state == RUN) begin
        acc  <= sum[WIDTH:1];
        mult <= {sum[0], mult[WIDTH-1:1]};
        cnt  <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed and random checks of the shared multiplier.
module tb_mul_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iReq0 = 1'b0, iReq1 = 1'b0;
  logic [15:0] iA0 = '0, iB0 = '0, iA1 = '0, iB1 = '0;
  logic        oGnt0, oGnt1, oDone0, oDone1, oBusy;
  logic [31:0] oResult;
  logic [15:0] oRL, oRH;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mul_scheduler #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iA0(iA0), .iB0(iB0),
    .iReq1(iReq1), .iA1(iA1), .iB1(iB1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
    .oResult(oResult), .oRL(oRL), .oRH(oRH), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation from an idle scheduler: request, grant, wait for done.
  task automatic run_op(input bit who, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    int  n;
    int  gc;
    int  extra;
    bit  got;
    @(negedge Clock);
    if (who) begin iReq1 = 1'b1; iA1 = a; iB1 = b; end
    else     begin iReq0 = 1'b1; iA0 = a; iB0 = b; end
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(negedge Clock); n++;
      if (oGnt0 || oGnt1) got = 1;
    end
    iReq0 = 1'b0; iReq1 = 1'b0;
    iA0 = 16'hDEAD; iB0 = 16'hBEEF; iA1 = 16'hDEAD; iB1 = 16'hBEEF;
    check("gnt_seen", 32'(got), 32'd1);
    check("gnt_wait", n, 1);
    check("gnt_owner", {30'b0, oGnt1, oGnt0}, who ? 32'd2 : 32'd1);
    check("busy_at_gnt", 32'(oBusy), 32'd1);
    gc = cyc;
    got = 0; n = 0; extra = 0;
    while (!got && n < 40) begin
      @(negedge Clock); n++;
      if (oGnt0 || oGnt1) extra++;
      if (oDone0 || oDone1) got = 1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("no_gnt_busy", extra, 0);
    check("done_owner", {30'b0, oDone1, oDone0}, who ? 32'd2 : 32'd1);
    check("latency", cyc - gc, 17);
    check("result", oResult, exp);
    check("rh", {16'b0, oRH}, {16'b0, exp[31:16]});
    check("rl", {16'b0, oRL}, {16'b0, exp[15:0]});
  endtask

  initial begin
    int          ng, nd, prev_gc;
    bit          bad;
    logic [15:0] ra, rb;
    bit          rw;

    // reset state
    repeat (2) @(negedge Clock);
    check("rst_outs", {oGnt0, oGnt1, oDone0, oDone1, oBusy}, 32'd0);
    check("rst_result", oResult, 32'd0);
    Reset = 1'b0;

    // directed single operations
    run_op(1'b0, 16'd3, 16'd5, 32'd15);
    run_op(1'b1, 16'hFFF9, 16'd6, 32'hFFFF_FFD6);
    run_op(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
    run_op(1'b1, 16'h8000, 16'd1, 32'hFFFF_8000);
    run_op(1'b0, 16'd0, 16'hFFFF, 32'd0);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 32'd1);

    // both requests held from reset: grants alternate 0,1,0,1 every 18 cycles
    @(negedge Clock);
    Reset = 1'b1;
    iReq0 = 1'b1; iA0 = 16'd100;   iB0 = 16'hFFFD;  // -300
    iReq1 = 1'b1; iA1 = 16'hFFFB;  iB1 = 16'hFFF7;  // 45
    @(negedge Clock);
    Reset = 1'b0;
    ng = 0; nd = 0; prev_gc = 0; bad = 0;
    for (int i = 0; i < 82; i++) begin
      @(negedge Clock);
      if ((oGnt0 && oGnt1) || (oDone0 && oDone1)) bad = 1;
      if ((oGnt0 || oGnt1) && ng < 4) begin
        check("alt_owner", 32'(oGnt1), 32'(ng % 2));
        if (ng > 0) check("alt_spacing", cyc - prev_gc, 18);
        prev_gc = cyc;
        ng++;
      end
      if (oDone0 || oDone1) begin
        check("alt_result", oResult, oDone1 ? 32'd45 : 32'hFFFF_FED4);
        nd++;
      end
    end
    check("alt_grants", ng, 4);
    check("alt_dones_min", 32'(nd >= 3), 32'd1);
    check("alt_exclusive", 32'(bad), 32'd0);
    iReq0 = 1'b0; iReq1 = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;

    // abort mid-RUN: asynchronous clear, no done, pointer back to reset value
    run_op(1'b1, 16'd7, 16'd9, 32'd63);
    @(negedge Clock);
    iReq0 = 1'b1; iA0 = 16'd3; iB0 = 16'd5;
    @(negedge Clock);
    iReq0 = 1'b0;
    repeat (5) @(negedge Clock);
    check("abort_busy_pre", 32'(oBusy), 32'd1);
    check("abort_result_pre", oResult, 32'd63);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_result", oResult, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      if (oDone0 || oDone1 || oBusy) nd++;
    end
    check("abort_quiet", nd, 0);
    iReq0 = 1'b1; iA0 = 16'd2; iB0 = 16'd2;
    iReq1 = 1'b1; iA1 = 16'd4; iB1 = 16'd4;
    @(negedge Clock);
    check("abort_ptr", {30'b0, oGnt1, oGnt0}, 32'd1);
    iReq0 = 1'b0; iReq1 = 1'b0;
    nd = 0;
    while (!(oDone0 || oDone1) && nd < 40) begin @(negedge Clock); nd++; end
    check("abort_next_result", oResult, 32'd4);

    // random operations against a signed reference
    for (int k = 0; k < 1000; k++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'($urandom_range(0, 2)) - 16'd1;
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      run_op(rw, ra, rb, 32'(int'($signed(ra)) * int'($signed(rb))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
